// File: rtl/rsa_asip_pkg.sv
// Shared types and sizing for the RSA ASIP execute stage.
package rsa_asip_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/blakley_step.sv
// One Blakley iteration: acc_next = (2*acc + (mul_bit ? op_a : 0)) reduced by up to two subtractions of mod_n.
module blakley_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH-1:0] op_a,
  input  logic             mul_bit,
  input  logic [WIDTH-1:0] mod_n,
  output logic [WIDTH+1:0] acc_next
);

  localparam int ACC_W = WIDTH + 2;

  logic [ACC_W-1:0] n_ext;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] t0;
  logic [ACC_W-1:0] t1;
  logic [ACC_W-1:0] t2;

  assign n_ext  = {2'b00, mod_n};
  assign addend = mul_bit ? {2'b00, op_a} : '0;

  // With acc < N and op_a < N the sum stays below 3N, so two reductions suffice.
  assign t0 = (acc << 1) + addend;
  assign t1 = (t0 >= n_ext) ? (t0 - n_ext) : t0;
  assign t2 = (t1 >= n_ext) ? (t1 - n_ext) : t1;

  assign acc_next = t2;

endmodule

// File: rtl/mod_mult_unit.sv
// Multi-cycle (opA*opB) mod modN, MSB-first, one multiplier bit per clock; done WIDTH+1 cycles after start.
// Optional MODMUL_ERR_CHECK_EN adds err and short-circuits invalid operands straight to DONE.
module mod_mult_unit
  import rsa_asip_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      opA,
  input  logic [WIDTH-1:0]      opB,
  input  logic [WIDTH-1:0]      modN,
  input  logic [REG_ADDR_W-1:0] destIn,
  output logic                  busy,
  output logic                  done,
  output logic                  wbEn,
  output logic [REG_ADDR_W-1:0] wbDest,
  output logic [WIDTH-1:0]      wbVal
`ifdef MODMUL_ERR_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ACC_W = WIDTH + 2;

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] mod_n_q;

  blakley_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .op_a     (op_a_q),
    .mul_bit  (op_b_q[bit_idx]),
    .mod_n    (mod_n_q),
    .acc_next (acc_next)
  );

`ifdef MODMUL_ERR_CHECK_EN
  logic op_bad;
  assign op_bad = (modN == '0) || (opA >= modN) || (opB >= modN);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wbEn    <= 1'b0;
      wbDest  <= '0;
      wbVal   <= '0;
      acc     <= '0;
      bit_idx <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      mod_n_q <= '0;
`ifdef MODMUL_ERR_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      wbEn <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a_q  <= opA;
            op_b_q  <= opB;
            mod_n_q <= modN;
            wbDest  <= destIn;
            acc     <= '0;
            bit_idx <= IDX_W'(WIDTH - 1);
            busy    <= 1'b1;
`ifdef MODMUL_ERR_CHECK_EN
            err     <= op_bad;
            if (op_bad) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          if (bit_idx == '0) begin
            state <= DONE;
            done  <= 1'b1;
            wbEn  <= 1'b1;
            wbVal <= acc_next[WIDTH-1:0];
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        DONE: begin
          // start is ignored here; the earliest new op is sampled in the following IDLE cycle.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_unit.sv
// Randomised and directed checks of mod_mult_unit against an arithmetic (a*b)%n reference.
module tb_mod_mult_unit;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic [15:0] modN = '0;
  logic [3:0]  destIn = '0;
  logic        busy;
  logic        done;
  logic        wbEn;
  logic [3:0]  wbDest;
  logic [15:0] wbVal;
`ifdef MODMUL_ERR_CHECK_EN
  logic        err;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_val = '0;

  mod_mult_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opA    (opA),
    .opB    (opB),
    .modN   (modN),
    .destIn (destIn),
    .busy   (busy),
    .done   (done),
    .wbEn   (wbEn),
    .wbDest (wbDest),
    .wbVal  (wbVal)
`ifdef MODMUL_ERR_CHECK_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n,
                        input logic [3:0] d, input bit keep);
    @(negedge clk);
    opA = a; opB = b; modN = n; destIn = d;
    start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  // Called at the negedge of cycle 1 after the start-sampling edge; returns on the first idle cycle.
  task automatic observe(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] n, input logic [3:0] d, input bit swap);
    bit          bad;
    logic [15:0] exp_val;
    int          exp_cyc;
    int          nb, nd, dc;
    bit          ended;
    logic        en_seen;
    logic [15:0] val_seen;
    logic [3:0]  dst_seen;
    bad = 1'b0;
`ifdef MODMUL_ERR_CHECK_EN
    bad = (n == 0) || (a >= n) || (b >= n);
`endif
    if (bad || n == 0) exp_val = last_val;
    else exp_val = 16'((64'(a) * 64'(b)) % 64'(n));
    exp_cyc = bad ? 1 : W + 1;
    nb = 0; nd = 0; dc = 0; ended = 1'b0;
    en_seen = 1'b0; val_seen = '0; dst_seen = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (swap && cyc == 5) begin
        opA = 16'd6; opB = 16'd6; modN = 16'd7; destIn = 4'd9;
      end
      if (busy) nb++;
      if (done) begin
        nd++; dc = cyc;
        en_seen = wbEn; val_seen = wbVal; dst_seen = wbDest;
      end
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " finished"}, 32'(ended), 32'd1);
    check({tag, " done_count"}, 32'(nd), 32'd1);
    check({tag, " done_cycle"}, 32'(dc), 32'(exp_cyc));
    check({tag, " busy_cycles"}, 32'(nb), 32'(exp_cyc));
    check({tag, " wbEn"}, 32'(en_seen), 32'(!bad));
    check({tag, " wbVal"}, 32'(val_seen), 32'(exp_val));
    check({tag, " wbDest"}, 32'(dst_seen), 32'(d));
`ifdef MODMUL_ERR_CHECK_EN
    check({tag, " err"}, 32'(err), 32'(bad));
`endif
    if (!bad) last_val = exp_val;
  endtask

  initial begin
    int wb_pulses;
    logic [15:0] ra, rb, rn;

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wbEn", 32'(wbEn), 32'd0);
    check("reset wbDest", 32'(wbDest), 32'd0);
    check("reset wbVal", 32'(wbVal), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    launch(16'd3, 16'd5, 16'd7, 4'd2, 1'b0);
    observe("basic", 16'd3, 16'd5, 16'd7, 4'd2, 1'b0);

    launch(16'hFFFE, 16'hFFFE, 16'hFFFF, 4'd5, 1'b0);
    observe("max", 16'hFFFE, 16'hFFFE, 16'hFFFF, 4'd5, 1'b0);

    launch(16'd0, 16'h1234, 16'h8000, 4'd7, 1'b0);
    observe("zeroA", 16'd0, 16'h1234, 16'h8000, 4'd7, 1'b0);

    // start held high throughout; operands change mid-run.
    launch(16'd5, 16'd4, 16'd11, 4'd3, 1'b1);
    observe("hold1", 16'd5, 16'd4, 16'd11, 4'd3, 1'b1);
    @(negedge clk);
    start = 1'b0;
    observe("hold2", 16'd6, 16'd6, 16'd7, 4'd9, 1'b0);

    launch(16'd3, 16'd5, 16'd7, 4'd2, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort wbEn", 32'(wbEn), 32'd0);
    check("abort wbVal", 32'(wbVal), 32'd0);
    check("abort wbDest", 32'(wbDest), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_val = '0;
    wb_pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (wbEn || done) wb_pulses++;
    end
    check("abort no_wb", 32'(wb_pulses), 32'd0);

    launch(16'd4, 16'd4, 16'd5, 4'd6, 1'b0);
    observe("post_abort", 16'd4, 16'd4, 16'd5, 4'd6, 1'b0);

    launch(16'd0, 16'd0, 16'd1, 4'd1, 1'b0);
    observe("mod1", 16'd0, 16'd0, 16'd1, 4'd1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rn = 16'($urandom_range(65535, 1));
      ra = 16'($urandom % 32'(rn));
      rb = 16'($urandom % 32'(rn));
      launch(ra, rb, rn, 4'($urandom_range(15, 0)), 1'b0);
      observe("rand", ra, rb, rn, destIn, 1'b0);
    end

`ifdef MODMUL_ERR_CHECK_EN
    launch(16'd3, 16'd2, 16'd0, 4'd4, 1'b0);
    observe("err_n0", 16'd3, 16'd2, 16'd0, 4'd4, 1'b0);
    launch(16'd9, 16'd2, 16'd7, 4'd5, 1'b0);
    observe("err_a", 16'd9, 16'd2, 16'd7, 4'd5, 1'b0);
    launch(16'd2, 16'd3, 16'd7, 4'd8, 1'b0);
    observe("err_clear", 16'd2, 16'd3, 16'd7, 4'd8, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
